// File: rtl/nibble_regrouper_pkg.sv
// nibble_regrouper_pkg
//   Shared defaults and helpers for the nibble_regrouper gearbox.
//   DEF_IN_W / DEF_OUT_W / DEF_BUF_W : default input width, output width and
//                                      accumulator capacity (bits).
//   cnt_w(buf_w)                     : width of a fill counter that must hold
//                                      every value 0..buf_w.
//   Optional feature macro used across the slice: GEARBOX_FLUSH_EN.
package nibble_regrouper_pkg;

  localparam int DEF_IN_W  = 4;
  localparam int DEF_OUT_W = 5;
  localparam int DEF_BUF_W = 12;

  function automatic int cnt_w(input int buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/nibble_regrouper_if.sv
// nibble_regrouper_if
//   Bundles both valid/ready streams of the gearbox.
//   in_valid / in_ready / in_data    : upstream word stream (IN_W bits, MSB oldest)
//   out_valid / out_ready / out_data : downstream symbol stream (OUT_W bits, MSB oldest)
//   flush / out_last                 : present only when GEARBOX_FLUSH_EN is defined
//   Modports: slave  = the gearbox's view (consumes input, produces output)
//             master = the environment's view (drives input, consumes output)
interface nibble_regrouper_if
  import nibble_regrouper_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
`ifdef GEARBOX_FLUSH_EN
  logic             flush;
  logic             out_last;

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, out_last
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
`endif

endinterface

// File: rtl/nibble_regrouper_regroup_acc.sv
// regroup_acc
//   Left-aligned bit accumulator: the valid bits live in acc[BUF_W-1 -: count].
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low
//   push     : append in_data after the held bits (after any same-cycle pop)
//   pop      : drop the oldest OUT_W bits (shift left, zero fill)
//   clear    : discard everything (used for the padded final symbol)
//   in_data  : IN_W-bit word, MSB oldest
//   head     : the oldest OUT_W bits, i.e. acc[BUF_W-1 -: OUT_W]
//   count    : number of valid bits held
module regroup_acc
  import nibble_regrouper_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int BUF_W = DEF_BUF_W,
  parameter int CW    = cnt_w(BUF_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] head,
  output logic [CW-1:0]    count
);

  logic [BUF_W-1:0] acc_reg, acc_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [BUF_W-1:0] acc_shifted;
  logic [CW-1:0]    base_cnt;
  logic [BUF_W-1:0] ins_aligned;

  always_comb begin
    acc_shifted = pop ? (acc_reg << OUT_W) : acc_reg;
    base_cnt    = pop ? (count_reg - CW'(OUT_W)) : count_reg;
    // New word lands directly below the bits that survive this cycle's pop.
    // Bits below count are always zero, so OR-ing in is sufficient.
    ins_aligned = {in_data, {(BUF_W-IN_W){1'b0}}} >> base_cnt;
    acc_next    = acc_shifted;
    count_next  = base_cnt;
    if (push) begin
      acc_next   = acc_shifted | ins_aligned;
      count_next = base_cnt + CW'(IN_W);
    end
    if (clear) begin
      acc_next   = '0;
      count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg   <= '0;
      count_reg <= '0;
    end else begin
      acc_reg   <= acc_next;
      count_reg <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_head
      assign head[gi] = acc_reg[BUF_W-OUT_W+gi];
    end
  endgenerate

  assign count = count_reg;

endmodule

// File: rtl/nibble_regrouper.sv
// nibble_regrouper
//   Regroups a stream of IN_W-bit words into OUT_W-bit symbols, MSB first
//   (default 4-bit nibbles -> 5-bit symbols). Receive end of the 5-in/4-out
//   serial shift chain on the adder datapath.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : nibble_regrouper_if.slave (in/out valid-ready streams; flush and
//           out_last exist only when GEARBOX_FLUSH_EN is defined)
//   With GEARBOX_FLUSH_EN, a flush pulse drains the residual (<OUT_W) bits as
//   one zero-padded symbol tagged out_last. Without it, residual bits wait for
//   more input.
//   Parameters: IN_W, OUT_W, BUF_W (BUF_W >= IN_W+OUT_W-1).
module nibble_regrouper
  import nibble_regrouper_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int BUF_W = DEF_BUF_W
) (
  input logic               clk,
  input logic               reset,
  nibble_regrouper_if.slave bus
);

  localparam int CW = cnt_w(BUF_W);

  generate
    if (BUF_W < IN_W + OUT_W - 1) begin : g_bad_buf_w
      $error("nibble_regrouper: BUF_W must be >= IN_W+OUT_W-1");
    end
  endgenerate

  logic [OUT_W-1:0] head;
  logic [CW-1:0]    count;
  logic             has_full;
  logic             has_room;
  logic             in_ready_i;
  logic             out_valid_i;
  logic             push;
  logic             pop;
  logic             clear;

  // Both flags come from the registered count only, so in_ready never
  // depends combinationally on out_ready.
  assign has_full = (count >= CW'(OUT_W));
  assign has_room = (count <= CW'(BUF_W - IN_W));

`ifdef GEARBOX_FLUSH_EN
  logic flush_pending_reg, flush_pending_next;
  logic residue;

  // The padded symbol is offered only once every full symbol has drained.
  assign residue     = flush_pending_reg && !has_full && (count != '0);
  assign in_ready_i  = has_room && !flush_pending_reg;
  assign out_valid_i = has_full || residue;
  assign clear       = residue && bus.out_ready;

  always_comb begin
    flush_pending_next = flush_pending_reg;
    if (clear) begin
      flush_pending_next = 1'b0;
    end else if (bus.flush && (count != '0)) begin
      flush_pending_next = 1'b1;
    end else if (flush_pending_reg && (count == '0)) begin
      // Held bits were an exact multiple of OUT_W: nothing left to pad.
      flush_pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_pending_reg <= 1'b0;
    end else begin
      flush_pending_reg <= flush_pending_next;
    end
  end

  assign bus.out_last = residue;
`else
  assign in_ready_i  = has_room;
  assign out_valid_i = has_full;
  assign clear       = 1'b0;
`endif

  assign push = bus.in_valid && in_ready_i;
  assign pop  = out_valid_i && bus.out_ready;

  regroup_acc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .BUF_W (BUF_W),
    .CW    (CW)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .in_data (bus.in_data),
    .head    (head),
    .count   (count)
  );

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_i;
  assign bus.out_data  = head;

endmodule

// File: tb/tb_nibble_regrouper.sv
// tb_nibble_regrouper
//   Directed self-checking bench for nibble_regrouper (IN_W=4, OUT_W=5,
//   BUF_W=12). Flush scenarios are compiled in when GEARBOX_FLUSH_EN is set.
module tb_nibble_regrouper;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  nibble_regrouper_if #(.IN_W(4), .OUT_W(5)) bus ();

  nibble_regrouper #(.IN_W(4), .OUT_W(5), .BUF_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.out_ready = 1'b0;
`ifdef GEARBOX_FLUSH_EN
    bus.flush     = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic push_word(input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (3) step();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++;
    if (bus.out_data !== 5'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", bus.out_data); end
    reset = 1'b1;
    repeat (4) step();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_out_valid got=%b want=0", bus.out_valid); end
    $display("reset: out_valid=%b in_ready=%b out_data=%h", bus.out_valid, bus.in_ready, bus.out_data);
  endtask

  task automatic test_stream();
    logic [3:0] nib [5];
    logic [4:0] sym [4];
    int i;
    int got;
    nib = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
    sym = '{5'h1E, 5'h03, 5'h18, 5'h0F};
    i = 0;
    got = 0;
    apply_reset();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      bus.in_valid = (i < 5);
      bus.in_data  = (i < 5) ? nib[i] : 4'h0;
      if (bus.out_valid) begin
        total++;
        if (got >= 4) begin
          bad++;
          $display("FAIL stream_extra_symbol got=%h want=none", bus.out_data);
        end else if (bus.out_data !== sym[got]) begin
          bad++;
          $display("FAIL stream_sym%0d got=%h want=%h", got, bus.out_data, sym[got]);
        end
        $display("stream: symbol %0d out_data=%h", got, bus.out_data);
        got++;
      end
      if (bus.in_valid && bus.in_ready) i++;
      step();
    end
    idle_inputs();
    total++;
    if (got !== 4) begin bad++; $display("FAIL stream_symbol_count got=%0d want=4", got); end
    total++;
    if (dut.u_acc.count !== 4'd0) begin bad++; $display("FAIL stream_final_count got=%0d want=0", dut.u_acc.count); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    push_word(4'h1);
    push_word(4'h2);
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_at_8 got=%b want=1", bus.in_ready); end
    push_word(4'h3);
    total++;
    if (dut.u_acc.count !== 4'd12) begin bad++; $display("FAIL bp_count_full got=%0d want=12", dut.u_acc.count); end
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", bus.in_ready); end
    // Upstream keeps offering a word; it must be refused without loss.
    push_word(4'h4);
    total++;
    if (dut.u_acc.count !== 4'd12) begin bad++; $display("FAIL bp_count_held got=%0d want=12", dut.u_acc.count); end
    bus.out_ready = 1'b1;
    total++;
    if (bus.out_data !== 5'h02) begin bad++; $display("FAIL bp_sym0 got=%h want=02", bus.out_data); end
    $display("backpressure: symbol 0 out_data=%h", bus.out_data);
    step();
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", bus.in_ready); end
    total++;
    if (bus.out_data !== 5'h08) begin bad++; $display("FAIL bp_sym1 got=%h want=08", bus.out_data); end
    $display("backpressure: symbol 1 out_data=%h", bus.out_data);
    step();
    bus.out_ready = 1'b0;
    total++;
    if (dut.u_acc.count !== 4'd2 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drained count=%0d out_valid=%b want count=2 out_valid=0", dut.u_acc.count, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_word(4'hA);
    push_word(4'hB);
    total++;
    if (dut.u_acc.count !== 4'd8) begin bad++; $display("FAIL b2b_count8 got=%0d want=8", dut.u_acc.count); end
    total++;
    if (bus.out_data !== 5'h15) begin bad++; $display("FAIL b2b_sym0 got=%h want=15", bus.out_data); end
    $display("back_to_back: symbol 0 out_data=%h", bus.out_data);
    bus.out_ready = 1'b1;
    push_word(4'hC);
    total++;
    if (dut.u_acc.count !== 4'd7) begin bad++; $display("FAIL b2b_count7 got=%0d want=7", dut.u_acc.count); end
    total++;
    if (bus.out_data !== 5'h0F) begin bad++; $display("FAIL b2b_sym1 got=%h want=0F", bus.out_data); end
    $display("back_to_back: symbol 1 out_data=%h", bus.out_data);
    push_word(4'hD);
    bus.out_ready = 1'b0;
    total++;
    if (dut.u_acc.count !== 4'd6) begin bad++; $display("FAIL b2b_count6 got=%0d want=6", dut.u_acc.count); end
    total++;
    if (bus.out_data !== 5'h06) begin bad++; $display("FAIL b2b_sym2 got=%h want=06", bus.out_data); end
    $display("back_to_back: symbol 2 out_data=%h", bus.out_data);
  endtask

  task automatic test_midstream_reset();
    apply_reset();
    push_word(4'hA);
    push_word(4'h5);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 5'h14) begin
      bad++;
      $display("FAIL mrst_before out_valid=%b out_data=%h want 1/14", bus.out_valid, bus.out_data);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mrst_async_valid got=%b want=0", bus.out_valid); end
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_data !== 5'h00) begin
      bad++;
      $display("FAIL mrst_async_state in_ready=%b out_data=%h want 1/00", bus.in_ready, bus.out_data);
    end
    step();
    reset = 1'b1;
    step();
    push_word(4'h0);
    push_word(4'h0);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 5'h00 || dut.u_acc.count !== 4'd8) begin
      bad++;
      $display("FAIL mrst_after out_valid=%b out_data=%h count=%0d want 1/00/8",
               bus.out_valid, bus.out_data, dut.u_acc.count);
    end
    $display("midstream_reset: first symbol out_data=%h", bus.out_data);
  endtask

`ifdef GEARBOX_FLUSH_EN
  task automatic test_flush();
    apply_reset();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      bad++;
      $display("FAIL flush_empty out_valid=%b out_last=%b want 0/0", bus.out_valid, bus.out_last);
    end
    push_word(4'hA);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 5'h14 || bus.out_last !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_residue v=%b d=%h last=%b rdy=%b want 1/14/1/0",
               bus.out_valid, bus.out_data, bus.out_last, bus.in_ready);
    end
    $display("flush: residue out_data=%h out_last=%b", bus.out_data, bus.out_last);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || dut.u_acc.count !== 4'd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_done v=%b last=%b count=%0d rdy=%b want 0/0/0/1",
               bus.out_valid, bus.out_last, dut.u_acc.count, bus.in_ready);
    end
    push_word(4'hA);
    push_word(4'h5);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    total++;
    if (bus.out_data !== 5'h14 || bus.out_last !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_full_first d=%h last=%b rdy=%b want 14/0/0", bus.out_data, bus.out_last, bus.in_ready);
    end
    $display("flush: full symbol out_data=%h out_last=%b", bus.out_data, bus.out_last);
    bus.out_ready = 1'b1;
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 5'h14 || bus.out_last !== 1'b1) begin
      bad++;
      $display("FAIL flush_full_residue v=%b d=%h last=%b want 1/14/1", bus.out_valid, bus.out_data, bus.out_last);
    end
    $display("flush: residue out_data=%h out_last=%b", bus.out_data, bus.out_last);
    step();
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || dut.u_acc.count !== 4'd0) begin
      bad++;
      $display("FAIL flush_full_done v=%b count=%0d want 0/0", bus.out_valid, dut.u_acc.count);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_midstream_reset();
`ifdef GEARBOX_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
